// File: rtl/level_read_arbiter_if.sv
// rtl/level_read_arbiter_if.sv - display/collision/level-memory bus bundle for level_read_arbiter
//
// Groups the three buses around the level map arbiter:
//   display side   : disp_req, disp_x, disp_y -> disp_valid, disp_data, disp_miss
//   collision side : col_req, col_x, col_y    -> col_ack, col_valid, col_data
//   memory side    : mem_en, mem_x, mem_y     <- mem_data (one cycle after mem_en)
// The slave modport is the arbiter's view; master is the view of its surroundings.
interface level_read_arbiter_if;
    logic       disp_req;
    logic [9:0] disp_x;
    logic [9:0] disp_y;
    logic       disp_valid;
    logic       disp_data;
    logic       disp_miss;

    logic       col_req;
    logic [9:0] col_x;
    logic [9:0] col_y;
    logic       col_ack;
    logic       col_valid;
    logic       col_data;

    logic       mem_en;
    logic [9:0] mem_x;
    logic [9:0] mem_y;
    logic       mem_data;

    modport slave (
        input  disp_req, disp_x, disp_y,
        output disp_valid, disp_data, disp_miss,
        input  col_req, col_x, col_y,
        output col_ack, col_valid, col_data,
        output mem_en, mem_x, mem_y,
        input  mem_data
    );

    modport master (
        output disp_req, disp_x, disp_y,
        input  disp_valid, disp_data, disp_miss,
        output col_req, col_x, col_y,
        input  col_ack, col_valid, col_data,
        input  mem_en, mem_x, mem_y,
        output mem_data
    );
endinterface

// File: rtl/level_read_arbiter.sv
// rtl/level_read_arbiter.sv - shares one synchronous-read level map between display and collision readers
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    level_read_arbiter_if.slave: display request/response, collision
//          request/ack/response, level memory read port
// Display wins every contested cycle except when the collision side has been
// denied STARVE_LIMIT consecutive cycles; then one display slot is stolen and
// the dropped pixel is recorded in the sticky disp_miss flag.
// Read latency is fixed at two clocks from the granting edge to the valid pulse.
module level_read_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input logic                 clk,
    input logic                 reset,
    level_read_arbiter_if.slave bus
);

    typedef enum logic {
        C_IDLE,
        C_WAIT
    } col_state_t;

    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam bit               STEAL_EN = (STARVE_LIMIT != 0);

    col_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_en_q, mem_en_d;
    logic [9:0]       mem_x_q, mem_x_d;
    logic [9:0]       mem_y_q, mem_y_d;
    logic             tag1_col_q, tag1_col_d;   // read issued this cycle belongs to collision
    logic             rd_v2_q, rd_v2_d;         // a read's data is on mem_data this cycle
    logic             tag2_col_q, tag2_col_d;
    logic             disp_valid_q, disp_valid_d;
    logic             disp_data_q, disp_data_d;
    logic             col_valid_q, col_valid_d;
    logic             col_data_q, col_data_d;
    logic             col_ack_q, col_ack_d;
    logic             disp_miss_q, disp_miss_d;

    logic col_elig;
    logic steal;
    logic grant_disp;
    logic grant_col;

    always_comb begin
        col_elig   = bus.col_req && (state_q == C_IDLE);
        steal      = col_elig && STEAL_EN && (cnt_q == LIMIT);
        grant_disp = bus.disp_req && !steal;
        grant_col  = col_elig && !grant_disp;

        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_x_d      = mem_x_q;
        mem_y_d      = mem_y_q;
        disp_data_d  = disp_data_q;
        col_data_d   = col_data_q;

        // Stage 0: issue the granted read.
        mem_en_d   = grant_disp || grant_col;
        tag1_col_d = grant_col;
        col_ack_d  = grant_col;
        if (grant_disp) begin
            mem_x_d = bus.disp_x;
            mem_y_d = bus.disp_y;
        end else if (grant_col) begin
            mem_x_d = bus.col_x;
            mem_y_d = bus.col_y;
        end

        // Stage 1: memory is answering; carry the tag alongside.
        rd_v2_d    = mem_en_q;
        tag2_col_d = tag1_col_q;

        // Stage 2: capture the answer and steer it to its owner.
        disp_valid_d = rd_v2_q && !tag2_col_q;
        col_valid_d  = rd_v2_q && tag2_col_q;
        if (disp_valid_d) disp_data_d = bus.mem_data;
        if (col_valid_d)  col_data_d  = bus.mem_data;

        // Counts consecutive denied eligible cycles; any break in eligibility restarts it.
        if (!col_elig || grant_col) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        disp_miss_d = disp_miss_q || (bus.disp_req && steal);

        // One collision read outstanding at a time.
        case (state_q)
            C_IDLE:  if (grant_col)   state_d = C_WAIT;
            C_WAIT:  if (col_valid_d) state_d = C_IDLE;
            default: state_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= C_IDLE;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_x_q      <= '0;
            mem_y_q      <= '0;
            tag1_col_q   <= 1'b0;
            rd_v2_q      <= 1'b0;
            tag2_col_q   <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= 1'b0;
            col_valid_q  <= 1'b0;
            col_data_q   <= 1'b0;
            col_ack_q    <= 1'b0;
            disp_miss_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_en_q     <= mem_en_d;
            mem_x_q      <= mem_x_d;
            mem_y_q      <= mem_y_d;
            tag1_col_q   <= tag1_col_d;
            rd_v2_q      <= rd_v2_d;
            tag2_col_q   <= tag2_col_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
            col_valid_q  <= col_valid_d;
            col_data_q   <= col_data_d;
            col_ack_q    <= col_ack_d;
            disp_miss_q  <= disp_miss_d;
        end
    end

    assign bus.mem_en     = mem_en_q;
    assign bus.mem_x      = mem_x_q;
    assign bus.mem_y      = mem_y_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.disp_data  = disp_data_q;
    assign bus.disp_miss  = disp_miss_q;
    assign bus.col_ack    = col_ack_q;
    assign bus.col_valid  = col_valid_q;
    assign bus.col_data   = col_data_q;

endmodule
